uart_rx_fifo: RTL and testbench

//   Receive-side buffer directly downstream of the UART receive path. Detects each
//   new received word (rising edge of rx_valid), stores {rx_err, rx_data} in a

---
 rtl/uart_rx_fifo.sv | 135 +++++++++++++
 tb/tb_uart_rx_fifo.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : Receive-side FIFO for a UART. Converts each rising edge of
//               rx_valid into one push of {rx_err, rx_data}, stores words in a
//               circular buffer and exposes the head entry on a show-ahead
//               read port. Words arriving while full are dropped and reported
//               through a sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
  parameter  int WIDTH_SIZE = 8,
  parameter  int DEPTH      = 16,
  localparam int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic                  rx_err,
  input  logic [WIDTH_SIZE-1:0] rx_data,
  input  logic                  rd_en,
  input  logic                  clr_ovf,
  output logic [WIDTH_SIZE-1:0] rd_data,
  output logic                  rd_err,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_W:0]       count,
  output logic                  overflow
);

  // Count value that means "every entry occupied".
  localparam logic [ADDR_W:0] C_DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

  // Storage: error flag in the MSB, data word below it.
  logic [WIDTH_SIZE:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q,  count_d;
  logic              empty_q,  empty_d;
  logic              full_q,   full_d;
  logic              overflow_q, overflow_d;
  logic              rx_valid_q, rx_valid_d;

  logic              w_push;
  logic              w_pop;
  logic              w_push_acc;
  logic              w_drop;
  logic [WIDTH_SIZE:0] w_head;

  // Edge detect on rx_valid, pop qualification and accept/drop decisions.
  always_comb begin
    rx_valid_d = rx_valid;
    w_push     = rx_valid & ~rx_valid_q;
    w_pop      = rd_en & ~empty_q;
    // A full FIFO can still take a word when a pop frees the slot in the same cycle.
    w_push_acc = w_push & (~full_q | w_pop);
    w_drop     = w_push & full_q & ~w_pop;
  end

  // Next-state for pointers, occupancy, status flags and sticky overflow.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (w_push_acc) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    count_d = count_q + (ADDR_W + 1)'(w_push_acc) - (ADDR_W + 1)'(w_pop);

    empty_d = (count_d == '0);
    full_d  = (count_d == C_DEPTH_CNT);

    // A drop in the same cycle as a clear must leave the flag set.
    if (w_drop) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  // Buffer write; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (!reset && w_push_acc) begin
      mem_q[wr_ptr_q] <= {rx_err, rx_data};
    end
  end

  // Show-ahead read port, forced to zero while nothing is stored.
  always_comb begin
    w_head  = mem_q[rd_ptr_q];
    rd_data = '0;
    rd_err  = 1'b0;
    if (!empty_q) begin
      rd_data = w_head[WIDTH_SIZE-1:0];
      rd_err  = w_head[WIDTH_SIZE];
    end
  end

  assign rd_valid = ~empty_q;
  assign empty    = empty_q;
  assign full     = full_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_fifo
// Description : Directed bench for uart_rx_fifo. Stimulus enqueues the words
//               it expects to read back; a monitor pops and compares on every
//               accepted host read. Status outputs are checked directly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

  localparam int W = 8;
  localparam int D = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_valid;
  logic       rx_err;
  logic [W-1:0] rx_data;
  logic       rd_en;
  logic       clr_ovf;
  logic [W-1:0] rd_data;
  logic       rd_err;
  logic       rd_valid;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overflow;

  int errors = 0;
  int checks = 0;

  logic [8:0] exp_q [$];
  logic [8:0] mon_exp;

  uart_rx_fifo #(.WIDTH_SIZE(W), .DEPTH(D)) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_valid (rx_valid),
    .rx_err   (rx_err),
    .rx_data  (rx_data),
    .rd_en    (rd_en),
    .clr_ovf  (clr_ovf),
    .rd_data  (rd_data),
    .rd_err   (rd_err),
    .rd_valid (rd_valid),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Monitor: every accepted read must match the oldest expected word.
  always @(negedge clk) begin
    if (!reset && rd_en && rd_valid) begin
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL pop_unexpected got=%h/%b expected none", rd_data, rd_err);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({rd_err, rd_data} !== mon_exp) begin
          errors = errors + 1;
          $display("FAIL pop_data got=%h/%b expected=%h/%b",
                   rd_data, rd_err, mon_exp[7:0], mon_exp[8]);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Present one word for 'hold' cycles then drop rx_valid for a cycle.
  task automatic push_word(input logic [7:0] d, input logic e, input int hold,
                           input bit stored);
    rx_data  = d;
    rx_err   = e;
    rx_valid = 1'b1;
    if (stored) exp_q.push_back({e, d});
    tick(hold);
    rx_valid = 1'b0;
    tick(1);
  endtask

  task automatic drain(input int n);
    rd_en = 1'b1;
    tick(n);
    rd_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; rx_valid = 1'b0; rx_err = 1'b0; rx_data = '0;
    rd_en = 1'b0; clr_ovf = 1'b0;
    tick(3);
    reset = 1'b0;

    // 1: reset state after idle
    tick(10);
    chk("rst_empty",    empty,    1);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_count",    count,    0);
    chk("rst_overflow", overflow, 0);
    chk("rst_rd_data",  rd_data,  0);
    chk("rst_full",     full,     0);

    // 2: two words with long rx_valid pulses, each counted once
    push_word(8'hA5, 1'b0, 4, 1'b1);
    push_word(8'h3C, 1'b1, 4, 1'b1);
    chk("t2_count",   count,   2);
    chk("t2_head",    rd_data, 8'hA5);
    chk("t2_head_er", rd_err,  0);
    drain(1);
    chk("t2_second",    rd_data, 8'h3C);
    chk("t2_second_er", rd_err,  1);
    drain(1);
    chk("t2_empty", empty, 1);

    // 3: fill, overflow drop, clear, drain in order
    for (int i = 0; i < 16; i++) push_word(8'(i), 1'b0, 1, 1'b1);
    chk("t3_full",  full,  1);
    chk("t3_count", count, 16);
    push_word(8'hFF, 1'b0, 1, 1'b0);
    chk("t3_ovf",       overflow, 1);
    chk("t3_count_ovf", count,    16);
    clr_ovf = 1'b1;
    tick(1);
    clr_ovf = 1'b0;
    chk("t3_ovf_clr", overflow, 0);
    drain(16);
    chk("t3_drained", empty, 1);

    // 4: push while full with a same-cycle read
    for (int i = 0; i < 16; i++) push_word(8'h10 + 8'(i), 1'b0, 1, 1'b1);
    chk("t4_full", full, 1);
    rx_data = 8'h55; rx_err = 1'b0; rx_valid = 1'b1; rd_en = 1'b1;
    exp_q.push_back({1'b0, 8'h55});
    tick(1);
    rd_en = 1'b0; rx_valid = 1'b0;
    tick(1);
    chk("t4_count", count,    16);
    chk("t4_ovf",   overflow, 0);
    drain(16);
    chk("t4_empty", empty, 1);

    // 5: push into empty FIFO with a same-cycle (ignored) read
    rx_data = 8'h77; rx_err = 1'b0; rx_valid = 1'b1; rd_en = 1'b1;
    exp_q.push_back({1'b0, 8'h77});
    tick(1);
    rd_en = 1'b0; rx_valid = 1'b0;
    chk("t5_count", count,   1);
    chk("t5_data",  rd_data, 8'h77);
    drain(1);
    chk("t5_empty", empty, 1);

    // 6: drop coinciding with clear keeps overflow set; reset flushes
    for (int i = 0; i < 16; i++) push_word(8'h20 + 8'(i), 1'b1, 1, 1'b1);
    rx_data = 8'hEE; rx_err = 1'b0; rx_valid = 1'b1; clr_ovf = 1'b1;
    tick(1);
    rx_valid = 1'b0; clr_ovf = 1'b0;
    tick(1);
    chk("t6_ovf_set_wins", overflow, 1);
    chk("t6_count_full",   count,    16);
    drain(11);
    chk("t6_count5", count, 5);
    reset = 1'b1;
    exp_q.delete();
    tick(1);
    chk("t6_rst_count", count,    0);
    chk("t6_rst_empty", empty,    1);
    chk("t6_rst_ovf",   overflow, 0);
    chk("t6_rst_data",  rd_data,  0);

    // rx_valid held high through reset release yields exactly one push
    rx_data = 8'h42; rx_err = 1'b1; rx_valid = 1'b1;
    tick(1);
    reset = 1'b0;
    exp_q.push_back({1'b1, 8'h42});
    tick(1);
    chk("rel_count1", count, 1);
    tick(3);
    chk("rel_count_hold", count, 1);
    rx_valid = 1'b0;
    tick(1);
    drain(1);
    chk("rel_empty", empty, 1);

    chk("scoreboard_left", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
